// File: rtl/vdma_pkg.sv
// Shared VDMA definitions: state encoding, direction names
// and the burst length helper used by both direction instances.
package vdma_pkg;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SYNC_WAIT = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_FIN       = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = S_IDLE,
        SYNC_WAIT = S_SYNC_WAIT,
        REQ       = S_REQ,
        WAIT_DONE = S_WAIT_DONE,
        FIN       = S_FIN
    } state_e;

    localparam string MODE_READ  = "READ";
    localparam string MODE_WRITE = "WRITE";

    function automatic logic [31:0] min_len(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_arm_counter.sv
// Counts consecutive fsync-low cycles; done_o fires on the
// cycle that completes a run of RST_WAIT low cycles.
module sync_arm_counter #(
    parameter int RST_WAIT = 32
) (
    input  logic clock,
    input  logic rst_n,
    input  logic en_i,
    input  logic fsync_i,
    output logic done_o
);

    localparam int CNT_W = (RST_WAIT > 1) ? $clog2(RST_WAIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign done_o = en_i && !fsync_i
                 && (cnt_q == CNT_W'(RST_WAIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!en_i || fsync_i || done_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_burst_scheduler.sv
// Issues AXI burst requests from line FIFO fill level and
// tracks the per-frame word budget, sizing the tail burst.
module fifo_burst_scheduler
    import vdma_pkg::*;
#(
    parameter string MODE      = "READ",
    parameter int    DEPTH     = 256,
    parameter int    CW        = 10,
    parameter int    BURST_LEN = 64,
    parameter int    LSIZE     = 9,
    parameter int    FW        = 24,
    parameter int    RST_WAIT  = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fsync,
    input  logic [FW-1:0]    frame_words,
    input  logic [CW-1:0]    count,
    output logic             req,
    output logic [LSIZE-1:0] req_len,
    output logic             req_last,
    input  logic             ack,
    input  logic             done,
    output logic             burst_done,
    output logic             frame_done,
    output logic             busy
);

    localparam bit IS_WRITE = (MODE == MODE_WRITE);

    state_e           state_q, state_d;
    logic [FW-1:0]    remaining_q, remaining_d;
    logic             sync_pend_q, sync_pend_d;
    logic             trig_q, trig_d;
    logic [LSIZE-1:0] req_len_q, req_len_d;
    logic             req_last_q, req_last_d;
    logic             req_q, burst_done_q, frame_done_q, busy_q;
    logic [31:0]      nl32;
    logic             arm_done;

    assign nl32 = min_len(32'(BURST_LEN), 32'(remaining_q));

    sync_arm_counter #(
        .RST_WAIT(RST_WAIT)
    ) u_arm (
        .clock  (clock),
        .rst_n  (rst_n),
        .en_i   (state_q == SYNC_WAIT),
        .fsync_i(fsync),
        .done_o (arm_done)
    );

    // READ waits for room, WRITE waits for data.
    always_comb begin
        trig_d = 1'b0;
        if (enable && remaining_q != '0) begin
            if (IS_WRITE) begin
                trig_d = 32'(count) >= nl32;
            end else begin
                trig_d = (32'(count) + nl32) <= 32'(DEPTH);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        sync_pend_d = sync_pend_q;
        req_len_d   = req_len_q;
        req_last_d  = req_last_q;
        unique case (state_q)
            IDLE: begin
                if (fsync || sync_pend_q) begin
                    state_d = SYNC_WAIT;
                end else if (trig_q) begin
                    state_d    = REQ;
                    req_len_d  = nl32[LSIZE-1:0];
                    req_last_d = (nl32 == 32'(remaining_q));
                end
            end
            SYNC_WAIT: begin
                if (arm_done) begin
                    state_d     = IDLE;
                    remaining_d = frame_words;
                    sync_pend_d = 1'b0;
                end
            end
            REQ: begin
                if (ack) begin
                    state_d     = WAIT_DONE;
                    remaining_d = remaining_q - FW'(req_len_q);
                end
            end
            WAIT_DONE: begin
                if (done) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A burst in flight is never aborted; remember the sync.
        if (fsync && (state_q == REQ || state_q == WAIT_DONE
                      || state_q == FIN)) begin
            sync_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            sync_pend_q  <= 1'b0;
            trig_q       <= 1'b0;
            req_len_q    <= '0;
            req_last_q   <= 1'b0;
            req_q        <= 1'b0;
            burst_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            sync_pend_q  <= sync_pend_d;
            trig_q       <= trig_d;
            req_len_q    <= req_len_d;
            req_last_q   <= req_last_d;
            req_q        <= (state_d == REQ);
            burst_done_q <= (state_d == FIN);
            frame_done_q <= (state_d == FIN) && (remaining_q == '0);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign req        = req_q;
    assign req_len    = req_len_q;
    assign req_last   = req_last_q;
    assign burst_done = burst_done_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fifo_burst_scheduler.sv
// Directed bench for fifo_burst_scheduler: a READ instance
// and a WRITE instance sharing clock and reset.
module tb_fifo_burst_scheduler;

    logic        clock = 1'b0;
    logic        rst_n;

    logic        enable, fsync, ack, done;
    logic [23:0] frame_words;
    logic [9:0]  count;
    logic        req, req_last, burst_done, frame_done, busy;
    logic [8:0]  req_len;

    logic        w_enable, w_fsync, w_ack, w_done;
    logic [23:0] w_frame_words;
    logic [9:0]  w_count;
    logic        w_req, w_req_last, w_burst_done, w_frame_done, w_busy;
    logic [8:0]  w_req_len;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    fifo_burst_scheduler #(.MODE("READ")) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (enable),
        .fsync      (fsync),
        .frame_words(frame_words),
        .count      (count),
        .req        (req),
        .req_len    (req_len),
        .req_last   (req_last),
        .ack        (ack),
        .done       (done),
        .burst_done (burst_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    fifo_burst_scheduler #(.MODE("WRITE")) dut_w (
        .clock      (clock),
        .rst_n      (rst_n),
        .enable     (w_enable),
        .fsync      (w_fsync),
        .frame_words(w_frame_words),
        .count      (w_count),
        .req        (w_req),
        .req_len    (w_req_len),
        .req_last   (w_req_last),
        .ack        (w_ack),
        .done       (w_done),
        .burst_done (w_burst_done),
        .frame_done (w_frame_done),
        .busy       (w_busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        for (int k = 0; k < 10 && !req; k++) step(1);
        chk(tag, 32'(req), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && busy; k++) step(1);
        chk(tag, 32'(busy), 0);
    endtask

    task automatic do_burst(input string tag, input int len,
                            input bit last, input bit fdone);
        wait_req({tag, "_req"});
        chk({tag, "_len"}, 32'(req_len), 32'(len));
        chk({tag, "_last"}, 32'(req_last), 32'(last));
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk({tag, "_req_drop"}, 32'(req), 0);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk({tag, "_bdone"}, 32'(burst_done), 1);
        chk({tag, "_fdone"}, 32'(frame_done), 32'(fdone));
        step(1);
        chk({tag, "_bdone_pulse"}, 32'(burst_done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; fsync = 1'b0; ack = 1'b0; done = 1'b0;
        frame_words = '0; count = '0;
        w_enable = 1'b0; w_fsync = 1'b0; w_ack = 1'b0; w_done = 1'b0;
        w_frame_words = '0; w_count = '0;
        step(2);
        chk("rst_req", 32'(req), 0);
        chk("rst_req_len", 32'(req_len), 0);
        chk("rst_req_last", 32'(req_last), 0);
        chk("rst_bdone", 32'(burst_done), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);

        rst_n = 1'b1;
        enable = 1'b1;
        step(3);
        chk("unarmed_req", 32'(req), 0);
        chk("unarmed_busy", 32'(busy), 0);

        // Frame of 200 words, empty FIFO: 64,64,64,8.
        frame_words = 24'd200;
        fsync = 1'b1;
        step(1);
        fsync = 1'b0;
        chk("arm_busy", 32'(busy), 1);
        step(31);
        chk("arm_sync_len", 32'(busy), 1);
        step(1);
        chk("arm_idle", 32'(busy), 0);
        for (int b = 0; b < 3; b++) do_burst("full", 64, 1'b0, 1'b0);
        do_burst("tail", 8, 1'b1, 1'b1);
        step(4);
        chk("frame_end_req", 32'(req), 0);
        chk("frame_end_busy", 32'(busy), 0);

        // Only 56 free words, then 64 free.
        count = 10'd200;
        fsync = 1'b1;
        step(1);
        fsync = 1'b0;
        wait_idle("arm2_idle");
        step(5);
        chk("space56_req", 32'(req), 0);
        count = 10'd192;
        step(1);
        chk("space64_lat1", 32'(req), 0);
        step(1);
        chk("space64_lat2", 32'(req), 1);
        chk("space64_len", 32'(req_len), 64);

        // fsync during WAIT_DONE: burst finishes, then re-arm.
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        frame_words = 24'd70;
        fsync = 1'b1;
        step(1);
        fsync = 1'b0;
        chk("wd_busy", 32'(busy), 1);
        done = 1'b1;
        step(1);
        done = 1'b0;
        chk("wd_bdone", 32'(burst_done), 1);
        step(1);
        chk("pend_fin_idle", 32'(busy), 0);
        step(1);
        chk("pend_sync", 32'(busy), 1);
        step(31);
        chk("pend_sync_len", 32'(busy), 1);
        step(1);
        chk("pend_rearm", 32'(busy), 0);
        do_burst("reload", 64, 1'b0, 1'b0);
        do_burst("reload_tail", 6, 1'b1, 1'b1);
        step(3);

        // Periodic fsync keeps the block in SYNC_WAIT.
        frame_words = 24'd0;
        for (int i = 0; i < 5; i++) begin
            fsync = 1'b1;
            step(1);
            fsync = 1'b0;
            chk("toggle_busy", 32'(busy), 1);
            step(9);
            chk("toggle_req", 32'(req), 0);
        end
        fsync = 1'b1;
        step(1);
        fsync = 1'b0;
        step(31);
        chk("toggle_hold", 32'(busy), 1);
        step(1);
        chk("toggle_exit", 32'(busy), 0);
        step(10);
        chk("zero_frame_req", 32'(req), 0);
        chk("zero_frame_busy", 32'(busy), 0);

        // Asynchronous reset in the middle of a request.
        count = 10'd0;
        frame_words = 24'd100;
        fsync = 1'b1;
        step(1);
        fsync = 1'b0;
        wait_idle("arm3_idle");
        wait_req("arm3_req");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(req), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_len", 32'(req_len), 0);
        rst_n = 1'b1;
        step(10);
        chk("post_rst_req", 32'(req), 0);
        chk("post_rst_busy", 32'(busy), 0);

        // WRITE direction: needs a full burst of data.
        w_enable = 1'b1;
        w_frame_words = 24'd128;
        w_count = 10'd63;
        w_fsync = 1'b1;
        step(1);
        w_fsync = 1'b0;
        for (int k = 0; k < 40 && w_busy; k++) step(1);
        chk("w_armed", 32'(w_busy), 0);
        step(5);
        chk("w_data63_req", 32'(w_req), 0);
        w_count = 10'd64;
        step(2);
        chk("w_data64_req", 32'(w_req), 1);
        chk("w_data64_len", 32'(w_req_len), 64);
        chk("w_data64_last", 32'(w_req_last), 0);
        w_ack = 1'b1;
        step(1);
        w_ack = 1'b0;
        chk("w_req_drop", 32'(w_req), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
